// File: rtl/inst_queue_if.sv
// Fetch/dispatch handshake bundle for the instruction queue.
// The queue sits on the slave modport. The fetch/dispatch side (or a bench) sits on the master modport.
interface inst_queue_if #(
  parameter int DEPTH = 6
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             enq_valid;
  logic             enq_ready;
  logic [31:0]      enq_pc;
  logic [31:0]      enq_inst;
  logic             enq_pred_taken;
  logic             deq_valid;
  logic             deq_ready;
  logic [31:0]      deq_pc;
  logic [31:0]      deq_inst;
  logic             deq_pred_taken;
  logic [CNT_W-1:0] count;

  modport master (
    output enq_valid, enq_pc, enq_inst, enq_pred_taken, deq_ready,
    input  enq_ready, deq_valid, deq_pc, deq_inst, deq_pred_taken, count
  );

  modport slave (
    input  enq_valid, enq_pc, enq_inst, enq_pred_taken, deq_ready,
    output enq_ready, deq_valid, deq_pc, deq_inst, deq_pred_taken, count
  );
endinterface

// File: rtl/inst_queue.sv
// Circular instruction queue between fetch and dispatch.
// It holds {pc, inst, pred_taken} per entry. The head is presented with first-word fall-through.
// A flush empties the queue in one cycle. Pointers wrap explicitly so DEPTH need not be a power of two.
module inst_queue #(
  parameter int DEPTH = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  inst_queue_if.slave   q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_cnt;

  logic [31:0]      r_memPc   [DEPTH];
  logic [31:0]      r_memInst [DEPTH];
  logic             r_memPred [DEPTH];

  logic             w_full;
  logic             w_empty;
  logic             w_doEnq;
  logic             w_doDeq;
  logic [PTR_W-1:0] w_wptrNext;
  logic [PTR_W-1:0] w_rptrNext;

  // Explicit wrap at DEPTH-1. A plain increment would walk into unused indices when DEPTH is not 2^n.
  function automatic logic [PTR_W-1:0] advance(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign w_full     = (r_cnt == CNT_W'(DEPTH));
  assign w_empty    = (r_cnt == '0);
  assign w_doEnq    = q.enq_valid & ~w_full;
  assign w_doDeq    = q.deq_ready & ~w_empty;
  assign w_wptrNext = advance(r_wptr);
  assign w_rptrNext = advance(r_rptr);

  assign q.enq_ready      = ~w_full;
  assign q.deq_valid      = ~w_empty;
  assign q.deq_pc         = r_memPc[r_rptr];
  assign q.deq_inst       = r_memInst[r_rptr];
  assign q.deq_pred_taken = r_memPred[r_rptr];
  assign q.count          = r_cnt;

  // Pointer and occupancy bookkeeping. Flush wins over any enqueue or dequeue in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_doEnq) r_wptr <= w_wptrNext;
      if (w_doDeq) r_rptr <= w_rptrNext;
      if (w_doEnq && !w_doDeq)
        r_cnt <= r_cnt + CNT_W'(1);
      else if (!w_doEnq && w_doDeq)
        r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Entry storage has no reset. Its contents only matter once the counter says they are valid.
  always_ff @(posedge clk) begin
    if (w_doEnq && !i_flush) begin
      r_memPc[r_wptr]   <= q.enq_pc;
      r_memInst[r_wptr] <= q.enq_inst;
      r_memPred[r_wptr] <= q.enq_pred_taken;
    end
  end
endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue.
// It runs a directed vector table, hand-written wrap and async-reset sequences, and random traffic.
// A queue-based reference model supplies the expected outputs.
module tb_inst_queue;
  localparam int DEPTH = 6;

  logic clk;
  logic rst;
  logic flush;

  inst_queue_if #(.DEPTH(DEPTH)) qIf ();

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_flush (flush),
    .q       (qIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
  } entry_t;

  typedef struct {
    logic        fl;
    logic        ev;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
    logic        dr;
    int          expCount;
    logic        expValid;
    logic        expReady;
    logic [31:0] expPc;
  } vec_t;

  entry_t modelQ[$];
  int     nCompared;
  int     nMismatched;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then update the model after the rising edge.
  task automatic applyStimulus(input logic fl, input logic ev, input logic [31:0] pc,
                               input logic [31:0] inst, input logic pred, input logic dr);
    bit enqOk;
    bit deqOk;
    entry_t e;
    @(negedge clk);
    flush              = fl;
    qIf.enq_valid      = ev;
    qIf.enq_pc         = pc;
    qIf.enq_inst       = inst;
    qIf.enq_pred_taken = pred;
    qIf.deq_ready      = dr;
    enqOk = ev && (modelQ.size() < DEPTH);
    deqOk = dr && (modelQ.size() > 0);
    e.pc = pc; e.inst = inst; e.pred = pred;
    @(posedge clk);
    #1;
    if (fl) modelQ.delete();
    else begin
      if (deqOk) void'(modelQ.pop_front());
      if (enqOk) modelQ.push_back(e);
    end
  endtask

  // Compare every observable output against the reference model.
  task automatic checkOutput(input string tag);
    check({tag, ".count"}, 32'(qIf.count), 32'(modelQ.size()));
    check({tag, ".deq_valid"}, 32'(qIf.deq_valid), 32'(modelQ.size() != 0));
    check({tag, ".enq_ready"}, 32'(qIf.enq_ready), 32'(modelQ.size() != DEPTH));
    if (modelQ.size() != 0) begin
      check({tag, ".deq_pc"}, qIf.deq_pc, modelQ[0].pc);
      check({tag, ".deq_inst"}, qIf.deq_inst, modelQ[0].inst);
      check({tag, ".deq_pred"}, 32'(qIf.deq_pred_taken), 32'(modelQ[0].pred));
    end
  endtask

  vec_t vecs[$];

  function automatic vec_t mk(input logic fl, input logic ev, input logic [31:0] pc,
                              input logic [31:0] inst, input logic pred, input logic dr,
                              input int c, input logic v, input logic r, input logic [31:0] hp);
    vec_t t;
    t.fl = fl; t.ev = ev; t.pc = pc; t.inst = inst; t.pred = pred; t.dr = dr;
    t.expCount = c; t.expValid = v; t.expReady = r; t.expPc = hp;
    return t;
  endfunction

  initial begin
    logic [31:0] expHead;
    nCompared   = 0;
    nMismatched = 0;

    rst = 1'b1; flush = 1'b0;
    qIf.enq_valid = 1'b0; qIf.enq_pc = '0; qIf.enq_inst = '0;
    qIf.enq_pred_taken = 1'b0; qIf.deq_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.count", 32'(qIf.count), 32'd0);
    check("reset.deq_valid", 32'(qIf.deq_valid), 32'd0);
    check("reset.enq_ready", 32'(qIf.enq_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Single enqueue, full fill, refused 7th enqueue, dequeue while full, flush, and enqueue after flush.
    vecs.push_back(mk(0, 1, 32'h60,  32'h00500093, 0, 0, 1, 1, 1, 32'h60));
    vecs.push_back(mk(0, 0, 32'h0,   32'h0,        0, 1, 0, 0, 1, 32'h0));
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(0, 1, 32'h100 + 32'(4 * i), 32'hA000 + 32'(i), 1'(i & 1), 0,
                        i + 1, 1, (i != 5), 32'h100));
    vecs.push_back(mk(0, 1, 32'h118, 32'hBAD,  1, 0, 6, 1, 0, 32'h100));
    vecs.push_back(mk(0, 1, 32'h11C, 32'hBAD,  1, 1, 5, 1, 1, 32'h104));
    vecs.push_back(mk(0, 0, 32'h0,   32'h0,    0, 1, 4, 1, 1, 32'h108));
    vecs.push_back(mk(1, 1, 32'h300, 32'hBAD,  0, 1, 0, 0, 1, 32'h0));
    vecs.push_back(mk(0, 1, 32'h200, 32'h1234, 1, 0, 1, 1, 1, 32'h200));
    vecs.push_back(mk(0, 0, 32'h0,   32'h0,    0, 1, 0, 0, 1, 32'h0));

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].fl, vecs[k].ev, vecs[k].pc, vecs[k].inst, vecs[k].pred, vecs[k].dr);
      check($sformatf("vec%0d.count", k), 32'(qIf.count), 32'(vecs[k].expCount));
      check($sformatf("vec%0d.deq_valid", k), 32'(qIf.deq_valid), 32'(vecs[k].expValid));
      check($sformatf("vec%0d.enq_ready", k), 32'(qIf.enq_ready), 32'(vecs[k].expReady));
      if (vecs[k].expValid)
        check($sformatf("vec%0d.deq_pc", k), qIf.deq_pc, vecs[k].expPc);
      checkOutput($sformatf("vec%0d.model", k));
    end

    // Wrap-around: prime three entries, then run twenty cycles of paired enqueue and dequeue.
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 1, 32'h400 + 32'(4 * i), 32'h5000 + 32'(i), 0, 0);
    checkOutput("wrap.prime");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 1, 32'h40C + 32'(4 * i), 32'h500C + 32'(i), 1'(i & 1), 1);
      expHead = 32'h404 + 32'(4 * i);
      check($sformatf("wrap%0d.head", i), qIf.deq_pc, expHead);
      check($sformatf("wrap%0d.count", i), 32'(qIf.count), 32'd3);
      checkOutput($sformatf("wrap%0d.model", i));
    end

    // Async reset with three entries, asserted between clock edges.
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0);
    check("areset.pre_count", 32'(qIf.count), 32'd3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("areset.deq_valid", 32'(qIf.deq_valid), 32'd0);
    check("areset.count", 32'(qIf.count), 32'd0);
    check("areset.enq_ready", 32'(qIf.enq_ready), 32'd1);
    modelQ.delete();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 1, 32'h700, 32'h00700113, 1, 0);
    check("areset.resume_pc", qIf.deq_pc, 32'h700);
    checkOutput("areset.resume");

    // Random traffic against the reference model, with an occasional flush.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 19) == 0), 1'($urandom), $urandom, $urandom,
                    1'($urandom), ($urandom_range(0, 2) != 0));
      checkOutput($sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
